// File: rtl/wb_user_pkg.sv
// Shared types and constants for the user-area Wishbone router.
package wb_user_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Upper 29 address bits of the two-register debug window at 0x300F_FFF8.
  localparam logic [28:0] DBG_ADR_HI   = 29'h601FFFF;
  // Upper 12 address bits of the user slave page.
  localparam logic [11:0] USER_PAGE    = 12'h300;
  // Read data returned when no slave answers or the address is unmapped.
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_user_decode.sv
// Combinational address decode: debug window, user slave index or unmapped.
module wb_user_decode
  import wb_user_pkg::*;
#(
  parameter int NSLV = 4
) (
  input  logic [31:3] adr_hi,
  output logic [3:0]  tgt_idx,
  output logic        is_dbg,
  output logic        unmapped
);

  localparam logic [4:0] NSLV_W = 5'(NSLV);

  // Debug window has priority over the user page; everything else is unmapped.
  always_comb begin
    tgt_idx  = adr_hi[19:16];
    is_dbg   = 1'b0;
    unmapped = 1'b1;
    if (adr_hi[31:3] == DBG_ADR_HI) begin
      is_dbg   = 1'b1;
      unmapped = 1'b0;
    end else if ((adr_hi[31:20] == USER_PAGE) && ({1'b0, adr_hi[19:16]} < NSLV_W)) begin
      unmapped = 1'b0;
    end
  end

endmodule

// File: rtl/wb_user_router.sv
// Registered Wishbone classic router: host -> NSLV user slaves or debug block,
// with a per-transaction timeout and a single registered host ack.
//
// Handshake: the host request is taken in IDLE when cyc & stb are high; the
// selected slave sees cyc/stb held until it acks (or timeout / host abort);
// the host ack is a one-cycle pulse in RESP and the host must drop stb after it.
module wb_user_router
  import wb_user_pkg::*;
#(
  parameter int          NSLV     = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic                 dbg_cyc_o,
  input  logic                 dbg_ack_i,
  input  logic [31:0]          dbg_dat_i,
  output logic                 err_o,
  output logic [7:0]           tmo_cnt_o,
  output logic [1:0]           state_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [3:0]      tgt_q;
  logic            dbg_q;

  logic [3:0]      dec_idx;
  logic            dec_dbg;
  logic            dec_unmapped;
  logic [NSLV-1:0] dec_onehot;
  logic            sel_ack;
  logic [31:0]     sel_dat;

  assign state_o = state;

  wb_user_decode #(.NSLV(NSLV)) u_decode (
    .adr_hi   (wbs_adr_i[31:3]),
    .tgt_idx  (dec_idx),
    .is_dbg   (dec_dbg),
    .unmapped (dec_unmapped)
  );

  // One-hot cycle vector for the newly decoded slave.
  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (dec_idx == 4'(k)) dec_onehot[k] = 1'b1;
    end
  end

  // Ack and read data of the latched target only; other slaves are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    if (dbg_q) begin
      sel_ack = dbg_ack_i;
      sel_dat = dbg_dat_i;
    end else begin
      for (int k = 0; k < NSLV; k++) begin
        if (tgt_q == 4'(k)) begin
          sel_ack = s_ack_i[k];
          sel_dat = s_dat_i[32*k +: 32];
        end
      end
    end
  end

  // Transaction FSM with registered slave-side and host-side outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      tgt_q     <= '0;
      dbg_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      s_cyc_o   <= '0;
      s_stb_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      dbg_cyc_o <= 1'b0;
      err_o     <= 1'b0;
      tmo_cnt_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            s_adr_o  <= wbs_adr_i;
            s_dat_o  <= wbs_dat_i;
            s_sel_o  <= wbs_sel_i;
            s_we_o   <= wbs_we_i;
            tgt_q    <= dec_idx;
            dbg_q    <= dec_dbg;
            wait_cnt <= '0;
            if (dec_unmapped) begin
              state     <= ST_RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= ERR_DATA;
              err_o     <= 1'b1;
              if (tmo_cnt_o != 8'hFF) tmo_cnt_o <= tmo_cnt_o + 8'd1;
            end else begin
              state   <= ST_BUSY;
              s_stb_o <= 1'b1;
              if (dec_dbg) dbg_cyc_o <= 1'b1;
              else         s_cyc_o   <= dec_onehot;
            end
          end
        end
        ST_BUSY: begin
          if (!wbs_cyc_i) begin
            // Host abort beats a simultaneous slave ack: no host ack.
            state     <= ST_IDLE;
            s_cyc_o   <= '0;
            dbg_cyc_o <= 1'b0;
            s_stb_o   <= 1'b0;
          end else if (sel_ack) begin
            // Slave ack beats a simultaneous timeout.
            state     <= ST_RESP;
            s_cyc_o   <= '0;
            dbg_cyc_o <= 1'b0;
            s_stb_o   <= 1'b0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= s_we_o ? 32'h0 : sel_dat;
          end else if (wait_cnt == TMO_LIMIT) begin
            state     <= ST_RESP;
            s_cyc_o   <= '0;
            dbg_cyc_o <= 1'b0;
            s_stb_o   <= 1'b0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= ERR_DATA;
            err_o     <= 1'b1;
            if (tmo_cnt_o != 8'hFF) tmo_cnt_o <= tmo_cnt_o + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_user_router.sv
// Directed bench for wb_user_router: scoreboard of expected host responses,
// behavioural slaves with programmable wait states, timing and side checks.
module tb_wb_user_router;

  localparam int NSLV    = 4;
  localparam int TIMEOUT = 8;
  localparam int W       = 33;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i;
  logic                wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]          wbs_sel_i;
  logic [31:0]         wbs_adr_i, wbs_dat_i;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic [NSLV-1:0]     s_cyc_o;
  logic                s_stb_o, s_we_o;
  logic [3:0]          s_sel_o;
  logic [31:0]         s_adr_o, s_dat_o;
  logic [NSLV-1:0]     s_ack_i;
  logic [32*NSLV-1:0]  s_dat_i;
  logic                dbg_cyc_o;
  logic                dbg_ack_i;
  logic [31:0]         dbg_dat_i;
  logic                err_o;
  logic [7:0]          tmo_cnt_o;
  logic [1:0]          state_o;

  // Slave model: wait state per slave, -1 means never ack.
  int                  slv_wait [NSLV];
  logic [31:0]         slv_data [NSLV];
  int                  dbg_wait;
  int                  bcnt;
  logic [NSLV-1:0]     stray_ack;

  logic [W-1:0]        exp_q[$];
  int                  n_cmp  = 0;
  int                  n_fail = 0;
  int                  exp_tmo = 0;

  wb_user_router #(.NSLV(NSLV), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o  (s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .dbg_cyc_o(dbg_cyc_o), .dbg_ack_i(dbg_ack_i), .dbg_dat_i(dbg_dat_i),
    .err_o    (err_o), .tmo_cnt_o(tmo_cnt_o), .state_o(state_o)
  );

  // Clock/reset block
  always #5 wb_clk_i = ~wb_clk_i;

  // Cycles since the current slave/debug cycle started (0 in the first one).
  always @(posedge wb_clk_i) begin
    if (s_cyc_o != '0 || dbg_cyc_o) bcnt <= bcnt + 1;
    else                            bcnt <= 0;
  end

  always_comb begin
    for (int k = 0; k < NSLV; k++) begin
      s_ack_i[k] = (s_cyc_o[k] && s_stb_o && slv_wait[k] >= 0 && bcnt >= slv_wait[k]) || stray_ack[k];
      s_dat_i[32*k +: 32] = slv_data[k];
    end
    dbg_ack_i = dbg_cyc_o && s_stb_o && dbg_wait >= 0 && bcnt >= dbg_wait;
    dbg_dat_i = 32'h0D0D_0D0D;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per host ack.
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_ack: got ack with data %0h, expected no ack", wbs_dat_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("ack_resp", {31'd0, err_o, wbs_dat_o}, {31'd0, e});
      end
    end else if (err_o) begin
      n_cmp++; n_fail++;
      $display("FAIL err_without_ack: got err_o=1, expected 0");
    end
  end

  // Driver: one host transaction with expected latency and side-band values.
  task automatic wb_req(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input int exp_lat, input logic [NSLV-1:0] exp_cyc, input logic exp_dbg,
                        input logic [31:0] exp_data, input logic exp_err);
    int n;
    if (exp_err && exp_tmo < 255) exp_tmo++;
    exp_q.push_back({exp_err, exp_data});
    @(negedge wb_clk_i);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_we_i = we; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1;
      n++;
      if (n == 1) begin
        chk("cyc_sel", {59'd0, exp_dbg, s_cyc_o}, {59'd0, exp_dbg ? 1'b1 : 1'b0, exp_cyc} & {59'd0, dbg_cyc_o | ~dbg_cyc_o, {NSLV{1'b1}}});
        chk("latched", {s_adr_o, s_dat_o}, {adr, dat});
        chk("dbg_cyc", {63'd0, dbg_cyc_o}, {63'd0, exp_dbg});
      end
    end while (!wbs_ack_o && n < 40);
    if (!wbs_ack_o) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_wait: got no ack after %0d cycles, expected ack at %0d", n, exp_lat);
    end else begin
      chk("latency", 64'(n), 64'(exp_lat));
      chk("tmo_cnt", {56'd0, tmo_cnt_o}, 64'(exp_tmo));
    end
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  // Driver: host drops cyc three cycles into BUSY; no ack may follow.
  task automatic wb_abort(input logic [31:0] adr);
    @(negedge wb_clk_i);
    wbs_adr_i = adr; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("abort_idle", {60'd0, state_o, s_stb_o, wbs_ack_o}, 64'd0);
    chk("abort_cyc", {59'd0, dbg_cyc_o, s_cyc_o}, 64'd0);
    repeat (3) @(posedge wb_clk_i);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    stray_ack = '0; bcnt = 0;
    slv_data[0] = 32'hC0DE_0000; slv_data[1] = 32'h1234_5678;
    slv_data[2] = 32'h2222_2222; slv_data[3] = 32'h3333_3333;
    for (int k = 0; k < NSLV; k++) slv_wait[k] = 0;
    dbg_wait = 0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("reset_outs", {wbs_ack_o, err_o, s_stb_o, dbg_cyc_o, s_cyc_o, tmo_cnt_o, state_o, wbs_dat_o},
        64'd0);
    wb_rst_i = 1'b0;

    // Reads and writes to user slaves and the debug window.
    wb_req(32'h3001_0004, 32'h0, 1'b0, 2, 4'b0010, 1'b0, 32'h1234_5678, 1'b0);
    dbg_wait = 1;
    wb_req(32'h300F_FFFC, 32'hA5A5_A5A5, 1'b1, 3, 4'b0000, 1'b1, 32'h0, 1'b0);
    dbg_wait = 0;
    wb_req(32'h300F_FFF8, 32'h0, 1'b0, 2, 4'b0000, 1'b1, 32'h0D0D_0D0D, 1'b0);
    // Timeout and unmapped accesses.
    slv_wait[0] = -1;
    wb_req(32'h3000_0000, 32'h0, 1'b0, TIMEOUT + 2, 4'b0001, 1'b0, 32'hDEAD_BEEF, 1'b1);
    wb_req(32'h3005_0000, 32'h0, 1'b0, 1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    wb_req(32'h4000_0010, 32'h0, 1'b1, 1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    // Wait states.
    slv_wait[3] = 1;
    wb_req(32'h3003_0008, 32'h5555_AAAA, 1'b1, 3, 4'b1000, 1'b0, 32'h0, 1'b0);
    slv_wait[2] = 3;
    wb_req(32'h3002_0000, 32'h0, 1'b0, 5, 4'b0100, 1'b0, 32'h2222_2222, 1'b0);
    // Ack lands on the timeout cycle: ack wins.
    slv_wait[0] = TIMEOUT;
    wb_req(32'h3000_0010, 32'h0, 1'b0, TIMEOUT + 2, 4'b0001, 1'b0, 32'hC0DE_0000, 1'b0);
    // Host abort with a silent slave, then with an ack in the abort cycle.
    slv_wait[0] = -1;
    wb_abort(32'h3000_0000);
    wb_req(32'h3001_0000, 32'h0, 1'b0, 2, 4'b0010, 1'b0, 32'h1234_5678, 1'b0);
    slv_wait[0] = 2;
    wb_abort(32'h3000_0004);
    wb_req(32'h3001_0000, 32'h0, 1'b0, 2, 4'b0010, 1'b0, 32'h1234_5678, 1'b0);
    // Acks from a non-selected slave are ignored.
    stray_ack = 4'b0100;
    wb_req(32'h3000_0000, 32'h0, 1'b0, 4, 4'b0001, 1'b0, 32'hC0DE_0000, 1'b0);
    stray_ack = '0;
    // Saturate the error counter.
    for (int i = 0; i < 300; i++)
      wb_req(32'h3007_0000 + 32'(i), 32'h0, 1'b0, 1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    chk("tmo_sat", {56'd0, tmo_cnt_o}, 64'd255);
    // Reset in the middle of a transaction.
    slv_wait[1] = -1;
    @(negedge wb_clk_i);
    wbs_adr_i = 32'h3001_0000; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("busy_before_rst", {59'd0, dbg_cyc_o, s_cyc_o}, 64'b0010);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("rst_mid_outs", {wbs_ack_o, err_o, s_stb_o, dbg_cyc_o, s_cyc_o, tmo_cnt_o, state_o, wbs_dat_o},
        64'd0);
    chk("rst_mid_bus", {s_adr_o, s_dat_o}, 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_user_router.md
# wb_user_router

Registered Wishbone classic-cycle router for the user project area. It decodes each host transaction from the management SoC into one of `NSLV` user slave windows or the reserved two-register debug window at `0x300F_FFF8`. It times out unresponsive slaves and returns a single registered ack to the host. It sits directly behind the `user_project_wrapper` Wishbone slave port and replaces the combinational user/debug address split.

## Interface
Parameters:
- `NSLV`, 4: number of user slave windows (1..16).
- `TIMEOUT`, 255: BUSY cycles without slave ack before an error response (1..255).
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on timeout or unmapped access.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i`  in  1  Wishbone clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  host request.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  host address and write data.
- `wbs_ack_o`  out  1  host ack, registered.
- `wbs_dat_o`  out  32  host read data, registered.
- `s_cyc_o`  out  NSLV  per-slave cycle, one-hot or zero.
- `s_stb_o`, `s_we_o`  out  1 each  shared strobe and write enable.
- `s_sel_o`  out  4  shared byte selects.
- `s_adr_o`, `s_dat_o`  out  32 each  shared address and write data (latched).
- `s_ack_i`  in  NSLV  per-slave ack.
- `s_dat_i`  in  32*NSLV  per-slave read data; slave k occupies `[32k+31:32k]`.
- `dbg_cyc_o`  out  1  debug register block cycle.
- `dbg_ack_i`  in  1  debug ack.
- `dbg_dat_i`  in  32  debug read data.
- `err_o`  out  1  one-cycle pulse on timeout or unmapped access.
- `tmo_cnt_o`  out  8  saturating count of timeouts and unmapped accesses.

## Operation
- Decode order:
  - `adr[31:3]==29'h601FFFF` selects debug.
  - Otherwise `adr[31:20]==12'h300` with `adr[19:16] < NSLV` selects slave `adr[19:16]`.
  - Any other address is unmapped.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - On `wbs_cyc_i & wbs_stb_i`: latch adr/dat/sel/we and the decoded target.
  - Mapped target: go to BUSY.
  - Unmapped target: go to RESP with `ERR_DATA`, pulse `err_o`, increment `tmo_cnt_o`.
- BUSY:
  - Drive the target's cyc with `s_stb_o`=1; all other cyc lines stay 0.
  - The wait counter increments each cycle.
  - Target ack seen: register its data (write cycles return 0), go to RESP.
  - Counter reaches `TIMEOUT` with no ack: go to RESP with `ERR_DATA`, pulse `err_o`, increment `tmo_cnt_o`.
  - `wbs_cyc_i` low (host abort): drop slave cyc/stb, go to IDLE, no ack.
- RESP: `wbs_ack_o`=1 for exactly one cycle, then IDLE. Slave cyc/stb are already low.
- `tmo_cnt_o` saturates at 255 and is cleared only by reset.
- A slave ack outside BUSY, or from a non-selected slave, is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Request sampled at edge E0. Slave cyc/stb high from E0 to the ack edge. `wbs_ack_o` high in the cycle after the slave ack.
- Zero-wait-state slave: host stb to ack is 2 cycles.
- Each slave wait state adds 1 cycle.
- Timeout: ack in cycle `TIMEOUT+2` after the request.
- Unmapped access: ack 1 cycle after the request.
- `wbs_dat_o` is valid only while `wbs_ack_o`=1 and is held otherwise.
- A request present in the RESP cycle is not accepted. The host must deassert stb after the ack; back-to-back requests restart from IDLE.
- Timeout and ack in the same BUSY cycle: the ack wins, no error.
- Abort and ack in the same cycle: the abort wins, no host ack.
- Reset asserted mid-transaction: next cycle IDLE, all slave cyc 0, no ack.

## Structure
- Package `wb_user_pkg`:
  - state enum.
  - `DBG_ADR_HI = 29'h601FFFF`.
  - `USER_PAGE = 12'h300`.
  - `ERR_DATA` default.
- One sub-module, `wb_user_decode`: combinational address to {target index, is_dbg, unmapped}.
- Everything else (FSM, counters, read mux) lives in `wb_user_router`.

## Test plan
- Read `0x3001_0004`, slave 1 acks in its first cycle with `0x1234_5678` -> `s_cyc_o`=4'b0010 for 1 cycle; `wbs_ack_o` 2 cycles after stb; `wbs_dat_o`=`0x1234_5678`.
- Write `0x300F_FFFC` data `0xA5A5_A5A5` -> `dbg_cyc_o` high, all `s_cyc_o`=0, `s_dat_o`=`0xA5A5_A5A5`; ack follows `dbg_ack_i` by 1 cycle.
- Read `0x3000_0000`, slave 0 never acks, `TIMEOUT`=8 -> ack at cycle 10 with `0xDEAD_BEEF`; `err_o` one pulse; `tmo_cnt_o`=1.
- Read `0x3005_0000` with `NSLV`=4 -> no `s_cyc_o`; ack 1 cycle later with `0xDEAD_BEEF`; `tmo_cnt_o` increments.
- Host drops cyc 3 cycles into BUSY -> slave cyc low next cycle, no `wbs_ack_o`; a new request then completes normally.
- 300 unmapped accesses -> `tmo_cnt_o` holds 255; `wb_rst_i` pulse -> 0 and all outputs 0.
